// File: rtl/fetch_pipeline_control.sv
// Fetch-side select sequencer: drives the PC, IR2 and PC2 muxes from stall/branch/restart requests.
// Optional build macro STALL_WATCHDOG_EN adds a sticky stall watchdog on stall_timeout.
module fetch_pipeline_control #(
  parameter int RESET_HOLD  = 2,
  parameter int FLUSH_SLOTS = 1,
  parameter int STALL_MAX   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_req,
  input  logic       branch_taken,
  input  logic       restart,
  output logic [1:0] selectmux0,
  output logic [1:0] selectmux1,
  output logic       selectmux2,
  output logic       busy,
  output logic [1:0] state,
  output logic       stall_timeout
);

  localparam int CMAX = (RESET_HOLD > FLUSH_SLOTS) ? RESET_HOLD : FLUSH_SLOTS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_BOOT  = CW'(RESET_HOLD);
  localparam logic [CW-1:0] CNT_FLUSH = CW'(FLUSH_SLOTS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  generate
    if (RESET_HOLD < 1 || FLUSH_SLOTS < 1 || STALL_MAX < 1) begin : g_bad_param
      $error("fetch_pipeline_control: RESET_HOLD, FLUSH_SLOTS and STALL_MAX must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, FLUSH = 2'd3} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= CNT_BOOT;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Selects are Mealy: registered state plus this cycle's requests.
  always_comb begin
    selectmux0 = 2'd1;
    selectmux1 = 2'd0;
    selectmux2 = 1'b0;
    state_n    = state_q;
    cnt_n      = cnt_q;
    if (restart) begin
      selectmux0 = 2'd0;
      selectmux1 = 2'd1;
      state_n    = BOOT;
      cnt_n      = CNT_BOOT;
    end else if (state_q == BOOT) begin
      selectmux0 = 2'd0;
      selectmux1 = 2'd1;
      if (cnt_q <= ONE) state_n = RUN;
      if (cnt_q != '0)  cnt_n   = cnt_q - ONE;
    end else if (branch_taken) begin
      selectmux0 = 2'd3;
      selectmux1 = 2'd1;
      if (FLUSH_SLOTS == 1) begin
        state_n = RUN;
      end else begin
        state_n = FLUSH;
        cnt_n   = CNT_FLUSH;
      end
    end else if (stall_req) begin
      selectmux0 = 2'd2;
      selectmux2 = 1'b1;
      if (state_q == FLUSH) begin
        selectmux1 = 2'd1;   // bubble stays in IR2, flush count frozen
      end else begin
        selectmux1 = 2'd2;
        state_n    = STALL;
      end
    end else if (state_q == FLUSH) begin
      selectmux1 = 2'd1;
      if (cnt_q <= ONE) state_n = RUN;
      if (cnt_q != '0)  cnt_n   = cnt_q - ONE;
    end else begin
      state_n = RUN;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != RUN);

`ifdef STALL_WATCHDOG_EN
  localparam int WW = $clog2(STALL_MAX + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(STALL_MAX);
  logic [WW-1:0] wd_q;
  logic          to_q;

  // selectmux2 high marks a cycle where a stall is actually holding the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (restart) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (selectmux2) begin
      if (wd_q != WD_MAX) wd_q <= wd_q + WW'(1);
      if (wd_q >= WD_MAX - WW'(1)) to_q <= 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign stall_timeout = to_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pipeline_control.sv
// Directed vector bench for fetch_pipeline_control (FLUSH_SLOTS=3 main instance, FLUSH_SLOTS=1 side instance).
module tb_fetch_pipeline_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall_req = 1'b0, branch_taken = 1'b0, restart = 1'b0;

  logic [1:0] s0, s1, st;
  logic       s2, bz, to;
  logic [1:0] s0b, s1b, stb;
  logic       s2b, bzb, tob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pipeline_control #(.RESET_HOLD(2), .FLUSH_SLOTS(3), .STALL_MAX(4)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
    .restart(restart), .selectmux0(s0), .selectmux1(s1), .selectmux2(s2),
    .busy(bz), .state(st), .stall_timeout(to));

  fetch_pipeline_control #(.RESET_HOLD(2), .FLUSH_SLOTS(1), .STALL_MAX(4)) dut1 (
    .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
    .restart(restart), .selectmux0(s0b), .selectmux1(s1b), .selectmux2(s2b),
    .busy(bzb), .state(stb), .stall_timeout(tob));

  typedef struct {
    logic       stall, br, rs;
    logic [1:0] s0, s1;
    logic       s2;
    logic [1:0] st;
    logic       bz;
  } vec_t;

  vec_t vecs[31];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_sel(input string tag, input int e0, input int e1, input int e2,
                         input int est, input int ebz);
    chk({tag, ".sel0"}, s0, e0);
    chk({tag, ".sel1"}, s1, e1);
    chk({tag, ".sel2"}, s2, e2);
    chk({tag, ".state"}, st, est);
    chk({tag, ".busy"}, bz, ebz);
`ifndef STALL_WATCHDOG_EN
    chk({tag, ".timeout"}, to, 0);
`endif
  endtask

  // Drive at a negedge, check 1ns later, finish on the next negedge.
  task automatic drive(input logic st_i, input logic br_i, input logic rs_i);
    stall_req = st_i; branch_taken = br_i; restart = rs_i;
    #1;
  endtask

  initial begin
    //          stall br rs  s0 s1 s2 st bz
    vecs[0]  = '{0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1};  // BOOT cnt 2
    vecs[1]  = '{0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1};  // BOOT cnt 1
    vecs[2]  = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd1, 0};  // RUN
    vecs[3]  = '{1, 0, 0, 2'd2, 2'd2, 1, 2'd1, 0};  // stall from RUN
    vecs[4]  = '{1, 0, 0, 2'd2, 2'd2, 1, 2'd2, 1};
    vecs[5]  = '{1, 0, 0, 2'd2, 2'd2, 1, 2'd2, 1};
    vecs[6]  = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd2, 1};  // release: run selects same cycle
    vecs[7]  = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd1, 0};
    vecs[8]  = '{0, 1, 0, 2'd3, 2'd1, 0, 2'd1, 0};  // branch
    vecs[9]  = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[10] = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[11] = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd1, 0};
    vecs[12] = '{0, 1, 0, 2'd3, 2'd1, 0, 2'd1, 0};  // branch, then stalled flush
    vecs[13] = '{1, 0, 0, 2'd2, 2'd1, 1, 2'd3, 1};
    vecs[14] = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[15] = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[16] = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd1, 0};
    vecs[17] = '{1, 1, 0, 2'd3, 2'd1, 0, 2'd1, 0};  // branch beats stall
    vecs[18] = '{0, 1, 0, 2'd3, 2'd1, 0, 2'd3, 1};  // branch in FLUSH reloads cnt
    vecs[19] = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[20] = '{1, 0, 0, 2'd2, 2'd1, 1, 2'd3, 1};
    vecs[21] = '{0, 0, 0, 2'd1, 2'd1, 0, 2'd3, 1};
    vecs[22] = '{1, 0, 0, 2'd2, 2'd2, 1, 2'd1, 0};
    vecs[23] = '{0, 1, 0, 2'd3, 2'd1, 0, 2'd2, 1};  // branch from STALL
    vecs[24] = '{0, 1, 1, 2'd0, 2'd1, 0, 2'd3, 1};  // restart beats branch
    vecs[25] = '{1, 1, 0, 2'd0, 2'd1, 0, 2'd0, 1};  // BOOT ignores branch/stall
    vecs[26] = '{0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1};
    vecs[27] = '{1, 0, 1, 2'd0, 2'd1, 0, 2'd1, 0};  // restart beats stall
    vecs[28] = '{0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1};
    vecs[29] = '{0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1};
    vecs[30] = '{0, 0, 0, 2'd1, 2'd0, 0, 2'd1, 0};

    #2 reset = 1'b1;
    #2 chk_sel("reset", 0, 1, 0, 0, 1);
    chk("reset.dut1_state", stb, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].rs);
      chk_sel($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].st, vecs[i].bz);
      @(negedge clk);
    end

    // Reset asserted mid-flush: outputs return to boot selects without waiting for a clock.
    drive(0, 1, 0);
    chk_sel("midflush.br", 3, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0);
    chk_sel("midflush.in", 1, 1, 0, 3, 1);
    reset = 1'b1;
    #1 chk_sel("midflush.rst", 0, 1, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0);
    chk_sel("reboot.c1", 0, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0);
    chk_sel("reboot.c2", 0, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0);
    chk_sel("reboot.run", 1, 0, 0, 1, 0);
    chk("f1.boot_done", stb, 1);
    @(negedge clk);

    // Single flush slot: branch returns straight to RUN.
    drive(0, 1, 0);
    chk("f1.br.sel0", s0b, 3);
    chk("f1.br.sel1", s1b, 1);
    chk("f1.br.sel2", s2b, 0);
    @(negedge clk);
    drive(0, 0, 0);
    chk("f1.after.state", stb, 1);
    chk("f1.after.busy", bzb, 0);
    chk("f1.after.sel0", s0b, 1);
    chk("f1.after.sel1", s1b, 0);
    chk_sel("f3.after", 1, 1, 0, 3, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

`ifdef STALL_WATCHDOG_EN
    // STALL_MAX=4: flag appears after the 4th consecutive stall cycle and stays.
    chk("wd.idle", to, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0);
      chk($sformatf("wd.stall%0d", k), to, 0);
      @(negedge clk);
    end
    drive(0, 0, 0);
    chk("wd.set", to, 1);
    @(negedge clk);
    drive(0, 0, 0);
    chk("wd.sticky", to, 1);
    @(negedge clk);
    drive(0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0);
    chk("wd.restart_clr", to, 0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
